// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer: operand hazard stall, comparator forwarding,
// wrong-path squash on taken branches and saturating branch statistics.
module branch_hazard_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int MAX_STALL   = 3,
    parameter bit FLUSH_TAKEN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 InstValidD,
    input  logic                 BranchCmpD,
    input  logic                 BranchRegD,
    input  logic                 BranchValD,
    input  logic [4:0]           RsD,
    input  logic [4:0]           RtD,
    input  logic                 RegWriteE,
    input  logic [4:0]           WriteRegE,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic [4:0]           WriteRegM,
    input  logic                 PCSrcD,
    input  logic                 StatClr,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushE,
    output logic                 FlushD,
    output logic                 ForwardAD,
    output logic                 ForwardBD,
    output logic                 BranchBusy,
    output logic                 StallTimeout,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] TakenCount,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int SCW = $clog2(MAX_STALL + 2);
    localparam logic [SCW-1:0] STALL_SAT = SCW'(MAX_STALL + 1);
    localparam logic [SCW-1:0] STALL_MAX = SCW'(MAX_STALL);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    logic [SCW-1:0] stall_cnt;
    logic [SCW-1:0] stall_nxt;

    logic br;
    logic use_a;
    logic use_b;
    logic haz_a;
    logic haz_b;
    logic haz;
    logic resolve;

    assign br    = InstValidD & (BranchCmpD | BranchRegD | BranchValD);
    assign use_a = BranchCmpD | BranchRegD;
    assign use_b = BranchCmpD;

    // $0 never carries a pending value, so it can neither stall nor forward
    assign haz_a = use_a && (RsD != 5'd0) &&
                   ((RegWriteE && WriteRegE == RsD) ||
                    (RegWriteM && MemtoRegM && WriteRegM == RsD));
    assign haz_b = use_b && (RtD != 5'd0) &&
                   ((RegWriteE && WriteRegE == RtD) ||
                    (RegWriteM && MemtoRegM && WriteRegM == RtD));

    assign haz     = br & (haz_a | haz_b);
    assign resolve = br & ~haz;

    assign StallF = haz;
    assign StallD = haz;
    assign FlushE = haz;
    assign FlushD = FLUSH_TAKEN & resolve & PCSrcD;

    assign ForwardAD = use_a && (RsD != 5'd0) && RegWriteM &&
                       !MemtoRegM && (WriteRegM == RsD);
    assign ForwardBD = use_b && (RtD != 5'd0) && RegWriteM &&
                       !MemtoRegM && (WriteRegM == RtD);

    assign BranchBusy = (state == WAIT);

    always_comb begin
        stall_nxt = '0;
        if (haz) begin
            if (state == WAIT) begin
                stall_nxt = (stall_cnt == STALL_SAT) ? STALL_SAT
                                                     : stall_cnt + SCW'(1);
            end else begin
                stall_nxt = SCW'(1);
            end
        end
    end

    // WAIT exits on any non-hazard cycle, including a killed D instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            stall_cnt    <= '0;
            StallTimeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= haz ? WAIT : IDLE;
                WAIT: state <= haz ? WAIT : IDLE;
                default: state <= IDLE;
            endcase
            stall_cnt <= stall_nxt;
            if (haz && stall_nxt > STALL_MAX) begin
                StallTimeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCount <= '0;
            TakenCount  <= '0;
            StallCount  <= '0;
        end else if (StatClr) begin
            BranchCount <= '0;
            TakenCount  <= '0;
            StallCount  <= '0;
        end else begin
            if (resolve && BranchCount != '1) begin
                BranchCount <= BranchCount + CNT_WIDTH'(1);
            end
            if (resolve && PCSrcD && TakenCount != '1) begin
                TakenCount <= TakenCount + CNT_WIDTH'(1);
            end
            if (haz && StallCount != '1) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_hazard_ctrl;

    localparam int CW = 4;
    localparam int MS = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic InstValidD, BranchCmpD, BranchRegD, BranchValD;
    logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
    logic RegWriteE, RegWriteM, MemtoRegM, PCSrcD, StatClr;
    logic StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD;
    logic BranchBusy, StallTimeout;
    logic [CW-1:0] BranchCount, TakenCount, StallCount;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(
        .CNT_WIDTH(CW),
        .MAX_STALL(MS),
        .FLUSH_TAKEN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .InstValidD(InstValidD), .BranchCmpD(BranchCmpD),
        .BranchRegD(BranchRegD), .BranchValD(BranchValD),
        .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegM(WriteRegM), .PCSrcD(PCSrcD), .StatClr(StatClr),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .FlushD(FlushD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .BranchBusy(BranchBusy), .StallTimeout(StallTimeout),
        .BranchCount(BranchCount), .TakenCount(TakenCount),
        .StallCount(StallCount)
    );

    typedef struct packed {
        logic valid, cmp, regb, val;
        logic [4:0] rs, rt;
        logic rwe;
        logic [4:0] wre;
        logic rwm, m2r;
        logic [4:0] wrm;
        logic pc, clr, rst;
    } stim_t;

    typedef struct packed {
        logic stall, flushd, fa, fb, busy, tmo;
        logic [CW-1:0] bc, tc, sc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // reference state: length of the current stall run, sticky flag, totals
    bit m_busy, m_tmo;
    int m_run, m_bc, m_tc, m_sc;

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic bit pend(logic [4:0] r, stim_t s);
        if (r == 5'd0) return 1'b0;
        return (s.rwe && s.wre == r) || (s.rwm && s.m2r && s.wrm == r);
    endfunction

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        bit br, ua, ub, haz, res;
        @(posedge clk);
        #1;
        rst_n = s.rst;
        InstValidD = s.valid; BranchCmpD = s.cmp;
        BranchRegD = s.regb;  BranchValD = s.val;
        RsD = s.rs; RtD = s.rt;
        RegWriteE = s.rwe; WriteRegE = s.wre;
        RegWriteM = s.rwm; MemtoRegM = s.m2r; WriteRegM = s.wrm;
        PCSrcD = s.pc; StatClr = s.clr;
        if (!s.rst) begin
            m_busy = 0; m_tmo = 0; m_run = 0;
            m_bc = 0; m_tc = 0; m_sc = 0;
        end
        br  = s.valid && (s.cmp || s.regb || s.val);
        ua  = s.cmp || s.regb;
        ub  = s.cmp;
        haz = br && ((ua && pend(s.rs, s)) || (ub && pend(s.rt, s)));
        res = br && !haz;
        e.stall  = haz;
        e.flushd = res && s.pc;
        e.fa = ua && s.rs != 0 && s.rwm && !s.m2r && s.wrm == s.rs;
        e.fb = ub && s.rt != 0 && s.rwm && !s.m2r && s.wrm == s.rt;
        e.busy = m_busy;
        e.tmo  = m_tmo;
        e.bc = m_bc[CW-1:0];
        e.tc = m_tc[CW-1:0];
        e.sc = m_sc[CW-1:0];
        q.push_back(e);
        if (s.rst) begin
            if (haz) begin
                m_run = m_busy ? m_run + 1 : 1;
                if (m_run > MS) m_tmo = 1;
            end else begin
                m_run = 0;
            end
            m_busy = haz;
            if (s.clr) begin
                m_bc = 0; m_tc = 0; m_sc = 0;
            end else begin
                m_bc = sat(m_bc + int'(res));
                m_tc = sat(m_tc + int'(res && s.pc));
                m_sc = sat(m_sc + int'(haz));
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("StallF", StallF, e.stall);
                chk("StallD", StallD, e.stall);
                chk("FlushE", FlushE, e.stall);
                chk("FlushD", FlushD, e.flushd);
                chk("ForwardAD", ForwardAD, e.fa);
                chk("ForwardBD", ForwardBD, e.fb);
                chk("BranchBusy", BranchBusy, e.busy);
                chk("StallTimeout", StallTimeout, e.tmo);
                chk("BranchCount", BranchCount, e.bc);
                chk("TakenCount", TakenCount, e.tc);
                chk("StallCount", StallCount, e.sc);
            end
        end
    end

    initial begin : driver
        stim_t s;
        int k;
        logic [4:0] pool [4];
        rst_n = 1'b0;
        {InstValidD, BranchCmpD, BranchRegD, BranchValD} = '0;
        {RsD, RtD, WriteRegE, WriteRegM} = '0;
        {RegWriteE, RegWriteM, MemtoRegM, PCSrcD, StatClr} = '0;

        s = nop(); s.rst = 0;
        cyc(s); cyc(s);
        // beq, no hazards, taken
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 5; s.rt = 6; s.pc = 1;
        cyc(s);
        cyc(nop());
        // beq behind ALU op: stall, then forward from MEM
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 5; s.rt = 6; s.pc = 1;
        s.rwe = 1; s.wre = 5;
        cyc(s);
        s.rwe = 0; s.wre = 0; s.rwm = 1; s.wrm = 5;
        cyc(s);
        cyc(nop());
        // jr behind lw: two stalls, then resolve without forward
        s = nop(); s.valid = 1; s.regb = 1; s.rs = 8;
        s.rwe = 1; s.wre = 8;
        cyc(s);
        s.rwe = 0; s.wre = 0; s.rwm = 1; s.m2r = 1; s.wrm = 8;
        cyc(s);
        s.rwm = 0; s.m2r = 0; s.wrm = 0;
        cyc(s);
        s = nop(); s.valid = 1; s.regb = 1; s.rs = 3; s.rt = 8;
        s.rwe = 1; s.wre = 8; s.rwm = 1; s.m2r = 1; s.wrm = 8;
        cyc(s);
        // $0 never hazards or forwards; j never stalls
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 0; s.rt = 0;
        s.rwe = 1; s.wre = 0; s.rwm = 1; s.wrm = 0;
        cyc(s);
        s = nop(); s.valid = 1; s.val = 1; s.rs = 5; s.rt = 6;
        s.rwe = 1; s.wre = 5; s.rwm = 1; s.m2r = 1; s.wrm = 6;
        cyc(s);
        // five-cycle stall drives the timeout, sticky until reset
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 9; s.rt = 10;
        s.rwe = 1; s.wre = 10;
        repeat (5) cyc(s);
        s.rwe = 0; s.pc = 1;
        cyc(s);
        repeat (3) cyc(nop());
        s = nop(); s.rst = 0;
        cyc(s);
        cyc(nop());
        // reset asserted mid-WAIT with StallCount at 7
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 4; s.rwm = 1;
        s.m2r = 1; s.wrm = 4;
        repeat (7) cyc(s);
        s.rst = 0;
        cyc(s);
        s.rst = 1;
        cyc(s);
        cyc(nop());
        // saturate all counters
        for (int i = 0; i < 20; i++) begin
            s = nop(); s.valid = 1; s.cmp = 1; s.rs = 7; s.rt = 2;
            s.rwe = 1; s.wre = 2;
            cyc(s);
            s.rwe = 0; s.pc = 1;
            cyc(s);
        end
        cyc(nop());
        // clear wins over a concurrent resolve
        s = nop(); s.valid = 1; s.cmp = 1; s.rs = 1; s.rt = 2;
        s.pc = 1; s.clr = 1;
        cyc(s);
        cyc(nop());

        for (int i = 0; i < 500; i++) begin
            pool[0] = 5'd0; pool[1] = 5'd5; pool[2] = 5'd8;
            pool[3] = 5'($urandom_range(0, 31));
            s = nop();
            s.valid = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 7);
            s.cmp  = k[0]; s.regb = k[1]; s.val = k[2];
            s.rs  = pool[$urandom_range(0, 3)];
            s.rt  = pool[$urandom_range(0, 3)];
            s.rwe = 1'($urandom);
            s.wre = pool[$urandom_range(0, 3)];
            s.rwm = 1'($urandom);
            s.m2r = 1'($urandom);
            s.wrm = pool[$urandom_range(0, 3)];
            s.pc  = 1'($urandom);
            s.clr = ($urandom_range(0, 31) == 0);
            s.rst = ($urandom_range(0, 63) != 0);
            cyc(s);
        end
        cyc(nop());

        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
